// File: rtl/switch_box_shadowed.sv
// Routing switch box: 4 sides x TRACKS tracks, per-output selectors in a shadow/active config store.
// Latency: routing is combinational (registered, 1 cycle, when SB_OUTPUT_REG_EN is defined); readback 1 cycle.
// Backpressure: none; a config write or commit is accepted every cycle.
module switch_box_shadowed #(
  parameter int TRACKS = 4,
  parameter int WIDTH  = 1,
  parameter int NUM_PE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [4*TRACKS*WIDTH-1:0]  in_wire,
  output logic [4*TRACKS*WIDTH-1:0]  out_wire,
  input  logic [NUM_PE*WIDTH-1:0]    pe_output,
  input  logic [7:0]                 config_addr,
  input  logic [31:0]                config_data,
  input  logic                       config_en,
  input  logic                       config_commit,
  output logic [31:0]                config_rdata,
  output logic                       cfg_dirty
);

  localparam int NSRC      = 3 + NUM_PE;
  localparam int SEL_W     = $clog2(NSRC);
  localparam int CFG_BITS  = 4 * TRACKS * SEL_W;
  localparam int CFG_WORDS = (CFG_BITS + 31) / 32;
  localparam int PAD_BITS  = CFG_WORDS * 32;
  localparam int NW        = 4 * TRACKS * WIDTH;

  logic [PAD_BITS-1:0] shadow_q;
  logic [PAD_BITS-1:0] shadow_d;
  logic [CFG_BITS-1:0] active_q;
  logic [31:0]         rdata_d;
  logic                wr_hit;
  logic [NW-1:0]       route;

  assign wr_hit = config_en && (int'(config_addr) < CFG_WORDS);

  // Next shadow includes this cycle's write so commit and readback both see it.
  always_comb begin
    shadow_d = shadow_q;
    for (int w = 0; w < CFG_WORDS; w++) begin
      if (wr_hit && int'(config_addr) == w)
        shadow_d[w*32 +: 32] = config_data;
    end
    for (int i = CFG_BITS; i < PAD_BITS; i++)
      shadow_d[i] = 1'b0;
    rdata_d = '0;
    for (int w = 0; w < CFG_WORDS; w++) begin
      if (int'(config_addr) == w)
        rdata_d = shadow_d[w*32 +: 32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q     <= '0;
      active_q     <= '0;
      config_rdata <= '0;
      cfg_dirty    <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      config_rdata <= rdata_d;
      if (config_commit) begin
        active_q  <= shadow_d[CFG_BITS-1:0];
        cfg_dirty <= 1'b0;
      end else if (wr_hit) begin
        cfg_dirty <= 1'b1;
      end
    end
  end

  // Selector k<3 takes a neighbouring side with a rotated track; 3+p takes a PE; the rest drive 0.
  always_comb begin
    logic [SEL_W-1:0] sel;
    sel   = '0;
    route = '0;
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < TRACKS; t++) begin
        sel = active_q[(s*TRACKS+t)*SEL_W +: SEL_W];
        for (int k = 0; k < 3; k++) begin
          if (int'(sel) == k)
            route[(s*TRACKS+t)*WIDTH +: WIDTH] =
              in_wire[(((s+1+k)%4)*TRACKS + (t+s+k)%TRACKS)*WIDTH +: WIDTH];
        end
        for (int p = 0; p < NUM_PE; p++) begin
          if (int'(sel) == 3 + p)
            route[(s*TRACKS+t)*WIDTH +: WIDTH] = pe_output[p*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef SB_OUTPUT_REG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_wire <= '0;
    else       out_wire <= route;
  end
`else
  assign out_wire = route;
`endif

endmodule

// File: tb/tb_switch_box_shadowed.sv
// Scoreboard bench for switch_box_shadowed: driver pushes expected post-edge state, monitor compares.
module tb_switch_box_shadowed;

  localparam int TRACKS    = 4;
  localparam int WIDTH     = 1;
  localparam int NUM_PE    = 2;
  localparam int NSRC      = 3 + NUM_PE;
  localparam int SEL_W     = $clog2(NSRC);
  localparam int CFG_BITS  = 4 * TRACKS * SEL_W;
  localparam int CFG_WORDS = (CFG_BITS + 31) / 32;
  localparam int NOUT      = 4 * TRACKS;
  localparam int NW        = NOUT * WIDTH;
  localparam int PW        = NUM_PE * WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NW-1:0] in_wire = '0;
  logic [NW-1:0] out_wire;
  logic [PW-1:0] pe_output = '0;
  logic [7:0]    config_addr = '0;
  logic [31:0]   config_data = '0;
  logic          config_en = 1'b0;
  logic          config_commit = 1'b0;
  logic [31:0]   config_rdata;
  logic          cfg_dirty;

  switch_box_shadowed #(.TRACKS(TRACKS), .WIDTH(WIDTH), .NUM_PE(NUM_PE)) dut (
    .clk(clk), .reset(reset), .in_wire(in_wire), .out_wire(out_wire),
    .pe_output(pe_output), .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .config_commit(config_commit),
    .config_rdata(config_rdata), .cfg_dirty(cfg_dirty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: config words, decoded selectors per output, dirty flag.
  logic [31:0] m_shadow [CFG_WORDS];
  int          m_sel [NOUT];
  bit          m_dirty;

  typedef struct {
    logic [NW-1:0] out;
    logic [31:0]   rdata;
    logic          dirty;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    for (int w = 0; w < CFG_WORDS; w++) m_shadow[w] = '0;
    for (int o = 0; o < NOUT; o++) m_sel[o] = 0;
    m_dirty = 1'b0;
  endfunction

  function automatic logic [NW-1:0] model_route(input logic [NW-1:0] iw, input logic [PW-1:0] pe);
    logic [NW-1:0] r;
    r = '0;
    for (int o = 0; o < NOUT; o++) begin
      int s, t, k, src;
      s = o / TRACKS;
      t = o % TRACKS;
      k = m_sel[o];
      if (k < 3) begin
        src = ((s + 1 + k) % 4) * TRACKS + (t + s + k) % TRACKS;
        r[o*WIDTH +: WIDTH] = iw[src*WIDTH +: WIDTH];
      end else if (k < NSRC) begin
        r[o*WIDTH +: WIDTH] = pe[(k-3)*WIDTH +: WIDTH];
      end
    end
    return r;
  endfunction

  // Config word w when every output uses selector v.
  function automatic logic [31:0] uniform_word(input int v, input int w);
    logic [CFG_WORDS*32-1:0] full;
    full = '0;
    for (int o = 0; o < NOUT; o++) full[o*SEL_W +: SEL_W] = SEL_W'(v);
    return full[w*32 +: 32];
  endfunction

  task automatic do_cycle(input bit en, input int addr, input logic [31:0] data,
                          input bit commit, input logic [NW-1:0] iw, input logic [PW-1:0] pe);
    exp_t e;
    @(negedge clk);
    config_en = en; config_addr = 8'(addr); config_data = data;
    config_commit = commit; in_wire = iw; pe_output = pe;
`ifdef SB_OUTPUT_REG_EN
    e.out = model_route(iw, pe);
`endif
    if (en && addr < CFG_WORDS) begin
      for (int b = 0; b < 32; b++)
        m_shadow[addr][b] = (addr*32 + b < CFG_BITS) ? data[b] : 1'b0;
      m_dirty = 1'b1;
    end
    if (commit) begin
      for (int o = 0; o < NOUT; o++) begin
        m_sel[o] = 0;
        for (int b = 0; b < SEL_W; b++) begin
          int i;
          i = o * SEL_W + b;
          if (m_shadow[i/32][i%32]) m_sel[o] += (1 << b);
        end
      end
      m_dirty = 1'b0;
    end
`ifndef SB_OUTPUT_REG_EN
    e.out = model_route(iw, pe);
`endif
    e.rdata = (addr < CFG_WORDS) ? m_shadow[addr] : 32'h0;
    e.dirty = m_dirty;
    exp_q.push_back(e);
  endtask

  bit mon_en = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_wire", 64'(out_wire), 64'(e.out));
        chk("config_rdata", 64'(config_rdata), 64'(e.rdata));
        chk("cfg_dirty", 64'(cfg_dirty), 64'(e.dirty));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW-1:0] ones;
    logic [NW-1:0] iw;
    logic [PW-1:0] pe;
    logic [NW-1:0] exp_out;
    ones = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", 64'(config_rdata), 64'h0);
    chk("reset_dirty", 64'(cfg_dirty), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // Reset routing, then write without commit, then commit.
    do_cycle(0, 0, 32'h0, 0, NW'(1) << (1*TRACKS + 0), '0);
    do_cycle(1, 0, 32'h1, 0, NW'(1) << (1*TRACKS + 0), '0);
    do_cycle(0, 0, 32'h0, 1, NW'(1) << (2*TRACKS + 1), '0);
    // All outputs to PE0, then PE1.
    do_cycle(1, 0, uniform_word(3, 0), 0, '0, '0);
    do_cycle(1, 1, uniform_word(3, 1), 1, '0, PW'(1));
    do_cycle(0, 0, 32'h0, 0, ones, PW'(0));
    do_cycle(1, 0, uniform_word(4, 0), 0, '0, PW'(2));
    do_cycle(1, 1, uniform_word(4, 1), 1, '0, PW'(2));
    // Write and commit together.
    do_cycle(1, 0, 32'h4000_0000, 1, NW'(1) << (1*TRACKS + 3), '0);
    // Out-of-range selector 6 on out 0,0 with everything driven high.
    do_cycle(1, 0, 32'h6, 1, ones, '1);
    do_cycle(0, 0, 32'h0, 0, ones, '1);
    // Out-of-range address and masked upper bits of the last word.
    do_cycle(1, 5, 32'hDEAD_BEEF, 0, ones, '1);
    do_cycle(1, 1, 32'hFFFF_FFFF, 0, '0, '0);
    do_cycle(0, 255, 32'h0, 1, ones, '0);

    for (int n = 0; n < 400; n++) begin
      int addr;
      addr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(CFG_WORDS, 255))
                                         : int'($urandom_range(0, CFG_WORDS - 1));
      do_cycle(($urandom_range(0, 1) == 1), addr, $urandom, ($urandom_range(0, 3) == 0),
               NW'($urandom), PW'($urandom));
    end

    // Ensure a non-trivial committed config, then reset mid-cycle during a write+commit.
    do_cycle(1, 0, $urandom | 32'h1, 0, NW'($urandom), PW'($urandom));
    do_cycle(1, 1, $urandom, 1, NW'($urandom), PW'($urandom));
    @(posedge clk);
    #3;
    chk("queue_drained_pre_reset", 64'(exp_q.size()), 64'h0);
    iw = NW'($urandom);
    pe = PW'($urandom);
    in_wire = iw; pe_output = pe;
    config_en = 1'b1; config_addr = 8'h0; config_data = $urandom; config_commit = 1'b1;
    reset = 1'b1;
    #1;
    model_reset();
`ifdef SB_OUTPUT_REG_EN
    exp_out = '0;
`else
    exp_out = model_route(iw, pe);
`endif
    chk("midreset_out", 64'(out_wire), 64'(exp_out));
    chk("midreset_rdata", 64'(config_rdata), 64'h0);
    chk("midreset_dirty", 64'(cfg_dirty), 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    config_en = 1'b0; config_commit = 1'b0; config_addr = 8'h0;

    do_cycle(0, 0, 32'h0, 0, iw, pe);
    do_cycle(0, 1, 32'h0, 0, NW'($urandom), pe);
    for (int n = 0; n < 100; n++) begin
      do_cycle(($urandom_range(0, 1) == 1), int'($urandom_range(0, CFG_WORDS)), $urandom,
               ($urandom_range(0, 2) == 0), NW'($urandom), PW'($urandom));
    end

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
